clock_setter: RTL and testbench

Button-driven time-setting controller that sits directly upstream of the display mux stage. It debounces the raw board keys and runs a RUN / SET_HOURS / SET_MINUTES state machine. It produces `hours_settings`, `minutes_settings` and `settings_signal` for the mux, where `settings_signal`=1 selects running time and 0 selects the setting values. On leaving setting mode it issues a one-cycle load strobe so the timekeeper adopts the edited time.

---
 rtl/clock_setter.sv | 170 +++++++++++++++++
 tb/tb_clock_setter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setter.sv
// clock_setter: debounced three-key time-setting controller feeding the display mux.
// Runs a RUN / SET_HOURS / SET_MINUTES state machine, edits hours/minutes settings and
// issues a one-cycle load_time strobe when leaving setting mode.
// Optional feature macro: CLOCK_SETTER_AUTOREPEAT_EN (auto-repeat while inc/dec is held).
module clock_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [6:0] minutes,
  input  logic [5:0] hours,
  output logic [6:0] minutes_settings,
  output logic [5:0] hours_settings,
  output logic       settings_signal,
  output logic       load_time
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StSetHours, StSetMinutes} state_e;

  // Key vector bit order: 0 = mode, 1 = inc, 2 = dec
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q, deb_q, press_q;
  logic [DbW-1:0] db_cnt_q [3];

  state_e     state_q, state_d;
  logic [5:0] hs_q, hs_d;
  logic [6:0] ms_q, ms_d;
  logic       ss_q, load_q, load_d;

  logic mode_ev, inc_ev, dec_ev, step_inc, step_dec;
  logic rep_inc, rep_dec;

  assign raw = {key_dec_n, key_inc_n, key_mode_n};

  // Synchronize raw keys, debounce with a stability counter, flag debounced 1->0 edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[k]    <= sync2_q[k];
          db_cnt_q[k] <= '0;
          press_q[k]  <= ~sync2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  assign mode_ev  = press_q[0];
  assign inc_ev   = press_q[1] | rep_inc;
  assign dec_ev   = press_q[2] | rep_dec;
  // Mode wins over edits; opposing edits in one cycle cancel
  assign step_inc = inc_ev & ~dec_ev & ~mode_ev;
  assign step_dec = dec_ev & ~inc_ev & ~mode_ev;

`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_q;
  logic            held_inc, held_dec, hold_run;

  assign held_inc = ~deb_q[1] & deb_q[2];
  assign held_dec = deb_q[1] & ~deb_q[2];
  assign hold_run = (state_q != StRun) & ~mode_ev & (held_inc | held_dec);

  // Held-key counter: first step after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!hold_run) begin
        rep_cnt_q <= '0;
      end else if (rep_cnt_q == RepW'(REPEAT_DELAY - 1)) begin
        rep_q     <= 1'b1;
        rep_cnt_q <= RepW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rep_cnt_q <= rep_cnt_q + RepW'(1);
      end
    end
  end

  assign rep_inc = rep_q & held_inc;
  assign rep_dec = rep_q & held_dec;
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  // Next state, settings edits with wrap, capture on entry and load strobe on exit
  always_comb begin
    state_d = state_q;
    hs_d    = hs_q;
    ms_d    = ms_q;
    load_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mode_ev) begin
          state_d = StSetHours;
          hs_d    = (hours > 6'd23) ? 6'd0 : hours;
          ms_d    = (minutes > 7'd59) ? 7'd0 : minutes;
        end
      end
      StSetHours: begin
        if (mode_ev) begin
          state_d = StSetMinutes;
        end else if (step_inc) begin
          hs_d = (hs_q == 6'd23) ? 6'd0 : hs_q + 6'd1;
        end else if (step_dec) begin
          hs_d = (hs_q == 6'd0) ? 6'd23 : hs_q - 6'd1;
        end
      end
      StSetMinutes: begin
        if (mode_ev) begin
          state_d = StRun;
          load_d  = 1'b1;
        end else if (step_inc) begin
          ms_d = (ms_q == 7'd59) ? 7'd0 : ms_q + 7'd1;
        end else if (step_dec) begin
          ms_d = (ms_q == 7'd0) ? 7'd59 : ms_q - 7'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State and registered outputs; settings_signal tracks the state on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      hs_q    <= '0;
      ms_q    <= '0;
      ss_q    <= 1'b1;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      ms_q    <= ms_d;
      ss_q    <= (state_d == StRun);
      load_q  <= load_d;
    end
  end

  assign hours_settings   = hs_q;
  assign minutes_settings = ms_q;
  assign settings_signal  = ss_q;
  assign load_time        = load_q;

endmodule

// File: tb/tb_clock_setter.sv
// Directed self-checking bench for clock_setter (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=5). A press takes 7 clock edges from the raw edge to the register update.
module tb_clock_setter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [6:0] minutes = '0;
  logic [5:0] hours = '0;
  logic [6:0] minutes_settings;
  logic [5:0] hours_settings;
  logic       settings_signal;
  logic       load_time;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  clock_setter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_mode_n      (key_mode_n),
    .key_inc_n       (key_inc_n),
    .key_dec_n       (key_dec_n),
    .minutes         (minutes),
    .hours           (hours),
    .minutes_settings(minutes_settings),
    .hours_settings  (hours_settings),
    .settings_signal (settings_signal),
    .load_time       (load_time)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, leaving time 1 unit past the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_set(input string tag, input int hs, input int ms, input int ss);
    check({tag, "_hours"}, 32'(hours_settings), hs);
    check({tag, "_minutes"}, 32'(minutes_settings), ms);
    check({tag, "_ss"}, 32'(settings_signal), ss);
  endtask

  task automatic keys(input bit m, input bit i, input bit d);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    key_dec_n  = ~d;
  endtask

  // Full press: hold until the update edge, then release and let the release settle
  task automatic press(input bit m, input bit i, input bit d);
    keys(m, i, d);
    tick(7);
    keys(0, 0, 0);
    tick(8);
  endtask

  initial begin
    // Reset state
    tick(2);
    check_set("reset", 0, 0, 1);
    check("reset_load", 32'(load_time), 0);
    rst_n = 1'b1;
    tick(2);

    // Capture 13:45 with exact press latency
    hours   = 6'd13;
    minutes = 7'd45;
    keys(1, 0, 0);
    tick(6);
    check("latency_pre_ss", 32'(settings_signal), 1);
    tick(1);
    check_set("capture", 13, 45, 0);
    check("capture_load", 32'(load_time), 0);
    keys(0, 0, 0);
    tick(8);

    // SET_HOURS -> SET_MINUTES, then exit with a single-cycle load strobe
    press(1, 0, 0);
    check("set_min_ss", 32'(settings_signal), 0);
    check("set_min_load", 32'(load_time), 0);
    keys(1, 0, 0);
    tick(7);
    check("exit_load", 32'(load_time), 1);
    check_set("exit", 13, 45, 1);
    tick(1);
    check("exit_load_drop", 32'(load_time), 0);
    keys(0, 0, 0);
    tick(8);

    // inc ignored in RUN
    press(0, 1, 0);
    check_set("run_inc", 13, 45, 1);

    // Wrap: hours 23 -> 0, minutes 0 -> 59
    hours   = 6'd23;
    minutes = 7'd0;
    press(1, 0, 0);
    check_set("cap23", 23, 0, 0);
    press(0, 1, 0);
    check_set("hwrap", 0, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check_set("mwrap", 0, 59, 0);

    // Debounce: 3-cycle glitch is rejected
    keys(0, 1, 0);
    tick(3);
    keys(0, 0, 0);
    tick(10);
    check("glitch", 32'(minutes_settings), 59);

    // 1-3-1 bounce then stable low gives exactly one increment
    keys(0, 1, 0);
    tick(1);
    keys(0, 0, 0);
    tick(3);
    keys(0, 1, 0);
    tick(1);
    keys(0, 0, 0);
    tick(1);
    check("bounce_mid", 32'(minutes_settings), 59);
    keys(0, 1, 0);
    tick(7);
    check("bounce_step", 32'(minutes_settings), 0);
    keys(0, 0, 0);
    tick(8);
    check_set("bounce_final", 0, 0, 0);

    // Mode + inc together in SET_HOURS at 5: mode wins, hours stays 5
    press(1, 0, 0);
    hours   = 6'd5;
    minutes = 7'd7;
    press(1, 0, 0);
    check_set("cap5", 5, 7, 0);
    press(1, 1, 0);
    check_set("mode_inc", 5, 7, 0);
    press(0, 1, 0);
    check_set("in_set_min", 5, 8, 0);
    press(0, 1, 1);
    check_set("inc_dec", 5, 8, 0);

    // Out-of-range running time is clamped at capture
    press(1, 0, 0);
    hours   = 6'd30;
    minutes = 7'd60;
    press(1, 0, 0);
    check_set("clamp", 0, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("clamp_back_ss", 32'(settings_signal), 1);

    // Held inc in SET_MINUTES from 10
    hours   = 6'd4;
    minutes = 7'd10;
    press(1, 0, 0);
    press(1, 0, 0);
    check_set("hold_start", 4, 10, 0);
    keys(0, 1, 0);
    tick(7);
    check("hold_press", 32'(minutes_settings), 11);
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    tick(19);
    check("rep_pre", 32'(minutes_settings), 11);
    tick(1);
    check("rep_20", 32'(minutes_settings), 12);
    tick(5);
    check("rep_25", 32'(minutes_settings), 13);
    tick(5);
    check("rep_30", 32'(minutes_settings), 14);
    keys(0, 0, 0);
    tick(5);
    check("rep_35", 32'(minutes_settings), 15);
    tick(20);
    check("rep_stop", 32'(minutes_settings), 15);
`else
    tick(28);
    check("norep_held", 32'(minutes_settings), 11);
    keys(0, 0, 0);
    tick(10);
    check("norep_release", 32'(minutes_settings), 11);
`endif
    press(1, 0, 0);

    // Reset while in SET_MINUTES at 07:30
    hours   = 6'd7;
    minutes = 7'd30;
    press(1, 0, 0);
    press(1, 0, 0);
    check_set("pre_rst", 7, 30, 0);
    rst_n = 1'b0;
    #1;
    check_set("mid_rst", 0, 0, 1);
    check("mid_rst_load", 32'(load_time), 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_set("post_rst", 0, 0, 1);
    check("post_rst_load", 32'(load_time), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
